// File: rtl/alu_seq.sv
// Multi-cycle EX-stage ALU with a valid/ready handshake on both sides.
// Single-cycle logic/arith/compare; shifts iterate SHIFT_STEP bits per cycle.
module alu_seq #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] STEP = SHW'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   cnt;
    logic             left;
    logic             fill;
  } shift_ctx_t;

  state_t           state, state_nxt;
  shift_ctx_t       sh;
  logic [SHW-1:0]   shamt, k, cnt_left;
  logic             is_shift, load_res, load_shift, do_step;
  logic [WIDTH-1:0] alu_res, step_res, res_d;
  logic [2*WIDTH-1:0] wide;

  assign shamt    = op_b[SHW-1:0];
  assign is_shift = (op_sel == 4'b0001) || (op_sel[2:0] == 3'b101);

  always_comb begin
    alu_res = '0;
    case (op_sel)
      4'b0000: alu_res = op_a + op_b;
      4'b1000: alu_res = op_a - op_b;
      4'b0010: alu_res[0] = $signed(op_a) < $signed(op_b);
      4'b0011: alu_res[0] = op_a < op_b;
      4'b0100: alu_res = op_a ^ op_b;
      4'b0110: alu_res = op_a | op_b;
      4'b0111: alu_res = op_a & op_b;
      4'b1111: alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  // Last step may be shorter than SHIFT_STEP; right shifts pull fill bits in from the top.
  assign k        = (sh.cnt < STEP) ? sh.cnt : STEP;
  assign cnt_left = sh.cnt - k;
  assign wide     = {{WIDTH{sh.fill}}, sh.work} >> k;
  assign step_res = sh.left ? (sh.work << k) : wide[WIDTH-1:0];

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    load_res   = 1'b0;
    load_shift = 1'b0;
    do_step    = 1'b0;
    res_d      = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (is_shift && shamt != '0) begin
            load_shift = 1'b1;
            state_nxt  = SHIFT;
          end else begin
            load_res  = 1'b1;
            res_d     = is_shift ? op_a : alu_res;
            state_nxt = DONE;
          end
        end
      end
      SHIFT: begin
        do_step = 1'b1;
        if (cnt_left == '0) begin
          load_res  = 1'b1;
          res_d     = step_res;
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh     <= '0;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      if (load_shift) begin
        sh.work <= op_a;
        sh.cnt  <= shamt;
        sh.left <= (op_sel == 4'b0001);
        sh.fill <= op_sel[3] & op_a[WIDTH-1];
      end else if (do_step) begin
        sh.work <= step_res;
        sh.cnt  <= cnt_left;
      end
      if (load_res) begin
        result <= res_d;
        zero   <= (res_d == '0);
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: per-cycle compare against a transaction-level model,
// plus literal expected results/latencies for each vector.
module tb_alu_seq;
  localparam int WIDTH = 32;
  localparam int STEP  = 1;

  logic             clk = 1'b0;
  logic             rst_n, in_valid, out_ready;
  logic             in_ready, out_valid, zero;
  logic [3:0]       op_sel;
  logic [WIDTH-1:0] op_a, op_b, result;

  int total = 0;
  int bad   = 0;

  alu_seq #(.WIDTH(WIDTH), .SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << sh;
      4'b0101: return a >> sh;
      4'b1101: return $unsigned($signed(a) >>> sh);
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0110: return a | b;
      4'b0111: return a & b;
      4'b1111: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    if ((op == 4'b0001 || op == 4'b0101 || op == 4'b1101) && sh != 0)
      return 1 + (sh + STEP - 1) / STEP;
    return 1;
  endfunction

  // Transaction model: 0 idle, 1 waiting out the latency, 2 result presented.
  int          m_state = 0;
  int          m_cnt   = 0;
  logic [31:0] m_pend  = '0;
  logic [31:0] m_res   = '0;
  logic        m_zero  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0;
      m_res   <= '0;
      m_zero  <= 1'b0;
    end else begin
      case (m_state)
        0: if (in_valid) begin
          if (model_lat(op_sel, op_b) == 1) begin
            m_state <= 2;
            m_res   <= model_res(op_sel, op_a, op_b);
            m_zero  <= (model_res(op_sel, op_a, op_b) == 0);
          end else begin
            m_state <= 1;
            m_cnt   <= model_lat(op_sel, op_b) - 1;
            m_pend  <= model_res(op_sel, op_a, op_b);
          end
        end
        1: if (m_cnt == 1) begin
          m_state <= 2;
          m_res   <= m_pend;
          m_zero  <= (m_pend == 0);
        end else m_cnt <= m_cnt - 1;
        default: if (out_ready) m_state <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("out_valid_vs_model", {31'd0, out_valid}, {31'd0, m_state == 2});
    chk("in_ready_vs_model",  {31'd0, in_ready},  {31'd0, m_state == 0});
    chk("result_vs_model",    result, m_res);
    chk("zero_vs_model",      {31'd0, zero}, {31'd0, m_zero});
  end

  // One op: input fields are scrambled right after accept to show they are ignored.
  task automatic run(input string name, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat, input int stall);
    int lat;
    @(negedge clk); #1;
    op_sel = op; op_a = a; op_b = b; in_valid = 1'b1; out_ready = (stall == 0);
    @(negedge clk); #1;
    lat    = 1;
    op_a   = $urandom; op_b = $urandom; op_sel = 4'($urandom);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk({name, "_lat"},    lat, exp_lat);
    chk({name, "_result"}, result, exp);
    chk({name, "_zero"},   {31'd0, zero}, {31'd0, exp == 0});
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      chk({name, "_held_valid"},  {31'd0, out_valid}, 32'd1);
      chk({name, "_held_result"}, result, exp);
      chk({name, "_held_ready"},  {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk({name, "_back_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op_sel = '0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result",    result, 32'd0);
    chk("reset_zero",      {31'd0, zero}, 32'd0);
    #1 rst_n = 1'b1;

    run("add_wrap",  4'b0000, 32'hFFFF_FFFF, 32'd1,        32'd0,          1,  0);
    run("sub",       4'b1000, 32'd5,         32'd7,        32'hFFFF_FFFE,  1,  0);
    run("slt",       4'b0010, 32'hFFFF_FFFF, 32'd1,        32'd1,          1,  0);
    run("sltu",      4'b0011, 32'hFFFF_FFFF, 32'd1,        32'd0,          1,  0);
    run("lui",       4'b1111, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000, 1,  0);
    run("xor",       4'b0100, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 1,  0);
    run("or",        4'b0110, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1,  0);
    run("and",       4'b0111, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1,  0);
    run("unlisted",  4'b1001, 32'h1234_5678, 32'h0000_0001, 32'd0,         1,  0);
    run("sra31",     4'b1101, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 32, 0);
    run("sll0",      4'b0001, 32'hA5A5_A5A5, 32'h0000_0000, 32'hA5A5_A5A5, 1,  0);
    run("srl4",      4'b0101, 32'hF000_0000, 32'd4,         32'h0F00_0000, 5,  0);
    run("sll_hibits",4'b0001, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010, 5,  0);
    run("sll31",     4'b0001, 32'h0000_0003, 32'd31,        32'h8000_0000, 32, 0);
    run("sra_pos",   4'b1101, 32'h4000_0000, 32'd2,         32'h1000_0000, 3,  0);
    run("bp_add",    4'b0000, 32'd2,         32'd3,         32'd5,         1,  5);
    run("bp_srl",    4'b0101, 32'h8000_0000, 32'd3,         32'h1000_0000, 4,  5);

    // Reset in the middle of a shift with 10 positions still to go.
    @(negedge clk); #1;
    op_sel = 4'b0101; op_a = 32'hFFFF_FFFF; op_b = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("midrst_result",    result, 32'd0);
    chk("midrst_zero",      {31'd0, zero}, 32'd0);
    #2 rst_n = 1'b1;
    run("post_rst_add", 4'b0000, 32'd2, 32'd3, 32'd5, 1, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
